cpumc_arb: RTL and testbench
============================

Name: cpumc_arb

Overview:
Arbitrates the CPU memory-controller bus (cpumc_a / cpumc_r_nw / cpumc_din) between three requesters: the rp2a03 core, the hci debug block and a burst DMA master (OAM/DMC/loader). It replaces the hci_active 2:1 mux at nes_top level with a registered-owner arbiter. Fixed priority is HCI > DMA > CPU. Every ownership change passes through exactly one read-only turnaround cycle. It also counts CPU stall cycles for NesDbg.

Parameters:
DMA_MAX_BURST, 0, max consecutive DMA_OWN cycles before the CPU is forced one bus cycle; 0 = unlimited.

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous active-high reset
cpu_a_in  input  16  rp2a03 address
cpu_r_nw_in  input  1  rp2a03 read/not-write
cpu_d_in  input  8  rp2a03 write data
cpu_rdy_out  output  1  rdy to rp2a03; high only while CPU owns the bus
hci_req_in  input  1  hci bus request (hci_active)
hci_a_in  input  16  hci address
hci_r_nw_in  input  1  hci read/not-write
hci_d_in  input  8  hci write data
hci_gnt_out  output  1  hci owns the bus
dma_req_in  input  1  DMA bus request (level)
dma_a_in  input  16  DMA address
dma_r_nw_in  input  1  DMA read/not-write
dma_d_in  input  8  DMA write data
dma_gnt_out  output  1  DMA owns the bus
bus_a_out  output  16  to cpumc_a
bus_r_nw_out  output  1  to cpumc_r_nw
bus_d_out  output  8  to cpumc_din
bus_owner_out  output  2  0=CPU, 1=TURN, 2=DMA, 3=HCI
stall_cnt_out  output  16  saturating count of cycles with cpu_rdy_out low
stall_cnt_clr_in  input  1  synchronous clear of stall_cnt_out

Behaviour:
- Clock is clk_in. Reset rst_in is synchronous and active-high.
- Reset (any state, including mid-DMA or mid-HCI): state=CPU_OWN, tgt=CPU, burst_cnt=0, stall_cnt=0.
  - Outputs after the reset edge: cpu_rdy_out=1, hci_gnt_out=0, dma_gnt_out=0, bus_owner_out=0, stall_cnt_out=0.
  - Bus outputs follow the cpu_* inputs.
- State register: CPU_OWN, TURN, DMA_OWN, HCI_OWN.
  - Gnt, rdy and bus_owner_out decode from registered state only. No combinational path from req to gnt.
  - Bus outputs mux combinationally from state.
- Bus mux by state:
  - CPU_OWN: cpu_*.
  - DMA_OWN: dma_*.
  - HCI_OWN: hci_*.
  - TURN: a=16'h0000, r_nw=1, d=8'h00. Always a read, so a TURN cycle never writes.
- Priority function P = hci_req ? HCI : dma_req ? DMA : CPU.
- Transitions, evaluated each rising edge:
  - CPU_OWN: if P!=CPU, go to TURN with tgt=P; otherwise stay.
  - TURN: always exactly 1 cycle. Next state = HCI if hci_req, else DMA if (tgt==DMA and dma_req), else CPU_OWN. Requests are re-evaluated here; a dropped request is skipped and no second TURN is inserted.
  - DMA_OWN: go to TURN with tgt=HCI if hci_req (preempt). Else go to TURN with tgt=CPU if !dma_req. Else go to TURN with tgt=CPU if DMA_MAX_BURST!=0 and burst_cnt==DMA_MAX_BURST-1. Otherwise stay.
  - HCI_OWN: stay while hci_req; go to TURN when it drops.
- Burst counter:
  - Increments each DMA_OWN cycle; resets to 0 on leaving DMA_OWN.
  - Width is clog2(DMA_MAX_BURST+1), minimum 1.
  - After a forced yield with dma_req still high: TURN→CPU_OWN (1 cycle, CPU gets one bus cycle)→TURN→DMA_OWN.
- Grant latency: request seen in CPU_OWN at edge N gives TURN at N+1 and gnt at N+2. Minimum 2 cycles.
- Requester contract:
  - Requesters hold a/r_nw/d stable while gnt is high.
  - A transfer completes on each clk_in edge with gnt high.
  - Read data is returned by the existing OR-bus.
  - A requester must not assume its transfer occurred when gnt drops.
- Preemption: HCI preemption of DMA drops dma_gnt_out the cycle TURN is entered. The DMA master retries its pending transfer after re-grant.
- cpu_rdy_out = (state==CPU_OWN). CPU is stalled in TURN, DMA_OWN and HCI_OWN.
- Stall counter:
  - Each edge: if stall_cnt_clr_in, cnt=0 (clear wins over increment); else if !cpu_rdy_out and cnt!=16'hFFFF, cnt+1.
  - Saturates at 16'hFFFF; no wrap.
- Simultaneous hci_req and dma_req in CPU_OWN: HCI wins. DMA is granted after HCI releases, via TURN.

Test Plan:
- Reset, no requests, CPU write A=0x0005 D=0x3C -> bus_a_out=0x0005, bus_r_nw_out=0, bus_d_out=0x3C, cpu_rdy_out=1, owner=0, stall_cnt=0.
- dma_req high 4 cycles from edge N, DMA_MAX_BURST=0 -> TURN at N+1 (bus a=0x0000, r_nw=1), dma_gnt N+2..N+4, then TURN, CPU_OWN; stall_cnt=5 (N+1 through N+5 — one lead-in TURN, three DMA_OWN, one exit TURN).
- DMA_MAX_BURST=256, dma_req held 600 cycles -> DMA_OWN runs of exactly 256, each followed by TURN, 1 CPU_OWN cycle (cpu_rdy_out=1), TURN; no write ever on a TURN cycle.
- hci_req asserted mid-DMA burst -> dma_gnt_out low next edge, 1 TURN, hci_gnt_out high; hci_req drops with dma_req still high -> TURN then DMA_OWN.
- hci_req and dma_req rise on the same edge in CPU_OWN -> hci granted first; dma_req dropped during the TURN target DMA -> CPU_OWN with no extra TURN.
- Preload stall_cnt to 0xFFFE via a long HCI hold -> saturates at 0xFFFF. Clear and stall on the same edge -> 0. rst_in pulse mid-DMA -> owner=0, gnts 0 next edge.

Source files
------------

// File: rtl/cpumc_arb.sv
// Registered-owner arbiter for the CPU memory-controller bus: HCI > DMA > CPU,
// with a read-only turnaround cycle on every ownership change and a CPU stall counter.
module cpumc_arb #(
  parameter int DMA_MAX_BURST = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  input  logic        hci_req_in,
  input  logic [15:0] hci_a_in,
  input  logic        hci_r_nw_in,
  input  logic [7:0]  hci_d_in,
  output logic        hci_gnt_out,
  input  logic        dma_req_in,
  input  logic [15:0] dma_a_in,
  input  logic        dma_r_nw_in,
  input  logic [7:0]  dma_d_in,
  output logic        dma_gnt_out,
  output logic [15:0] bus_a_out,
  output logic        bus_r_nw_out,
  output logic [7:0]  bus_d_out,
  output logic [1:0]  bus_owner_out,
  output logic [15:0] stall_cnt_out,
  input  logic        stall_cnt_clr_in
);

  // State encoding doubles as the bus_owner_out code.
  localparam logic [1:0] ST_CPU  = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_DMA  = 2'd2;
  localparam logic [1:0] ST_HCI  = 2'd3;

  localparam int BW = (DMA_MAX_BURST == 0) ? 1 : $clog2(DMA_MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'((DMA_MAX_BURST == 0) ? 0 : DMA_MAX_BURST - 1);
  localparam bit BURST_LIMITED = (DMA_MAX_BURST != 0);

  logic [1:0]    state_q, state_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [15:0]   stall_q, stall_d;
  logic [1:0]    prio;
  logic          burstDone;

  assign prio      = hci_req_in ? ST_HCI : (dma_req_in ? ST_DMA : ST_CPU);
  assign burstDone = BURST_LIMITED && (burst_q == BURST_LAST);

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_CPU: begin
        if (prio != ST_CPU) begin
          state_d = ST_TURN;
          tgt_d   = prio;
        end
      end
      ST_TURN: begin
        // Requests are re-sampled here, so a withdrawn request falls straight to the CPU.
        if (hci_req_in)                         state_d = ST_HCI;
        else if (tgt_q == ST_DMA && dma_req_in) state_d = ST_DMA;
        else                                    state_d = ST_CPU;
      end
      ST_DMA: begin
        if (hci_req_in) begin
          state_d = ST_TURN;
          tgt_d   = ST_HCI;
        end else if (!dma_req_in || burstDone) begin
          state_d = ST_TURN;
          tgt_d   = ST_CPU;
        end
      end
      default: begin
        if (!hci_req_in) begin
          state_d = ST_TURN;
          tgt_d   = dma_req_in ? ST_DMA : ST_CPU;
        end
      end
    endcase
  end

  always_comb begin
    burst_d = '0;
    if (state_q == ST_DMA && state_d == ST_DMA) burst_d = burst_q + 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    if (stall_cnt_clr_in)                              stall_d = '0;
    else if (state_q != ST_CPU && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_CPU;
      tgt_q   <= ST_CPU;
      burst_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
    end
  end

  assign cpu_rdy_out   = (state_q == ST_CPU);
  assign dma_gnt_out   = (state_q == ST_DMA);
  assign hci_gnt_out   = (state_q == ST_HCI);
  assign bus_owner_out = state_q;
  assign stall_cnt_out = stall_q;

  // TURN drives a harmless read of address 0 so the turnaround can never write.
  always_comb begin
    bus_a_out    = 16'h0000;
    bus_r_nw_out = 1'b1;
    bus_d_out    = 8'h00;
    case (state_q)
      ST_CPU: begin
        bus_a_out    = cpu_a_in;
        bus_r_nw_out = cpu_r_nw_in;
        bus_d_out    = cpu_d_in;
      end
      ST_DMA: begin
        bus_a_out    = dma_a_in;
        bus_r_nw_out = dma_r_nw_in;
        bus_d_out    = dma_d_in;
      end
      ST_HCI: begin
        bus_a_out    = hci_a_in;
        bus_r_nw_out = hci_r_nw_in;
        bus_d_out    = hci_d_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpumc_arb.sv
// Directed bench for cpumc_arb: instance "A" has unlimited DMA bursts, instance "B"
// limits bursts to 256; both see identical stimulus.
module tb_cpumc_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpuA, hciA, dmaA;
  logic        cpuRnw, hciRnw, dmaRnw;
  logic [7:0]  cpuD, hciD, dmaD;
  logic        hciReq, dmaReq, stallClr;

  logic        aRdy, aHciGnt, aDmaGnt, aRnw;
  logic [15:0] aBusA, aStall;
  logic [7:0]  aBusD;
  logic [1:0]  aOwner;
  logic        bRdy, bHciGnt, bDmaGnt, bRnw;
  logic [15:0] bBusA, bStall;
  logic [7:0]  bBusD;
  logic [1:0]  bOwner;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  cpumc_arb #(.DMA_MAX_BURST(0)) dutA (
    .clk_in(clk), .rst_in(rst),
    .cpu_a_in(cpuA), .cpu_r_nw_in(cpuRnw), .cpu_d_in(cpuD), .cpu_rdy_out(aRdy),
    .hci_req_in(hciReq), .hci_a_in(hciA), .hci_r_nw_in(hciRnw), .hci_d_in(hciD),
    .hci_gnt_out(aHciGnt),
    .dma_req_in(dmaReq), .dma_a_in(dmaA), .dma_r_nw_in(dmaRnw), .dma_d_in(dmaD),
    .dma_gnt_out(aDmaGnt),
    .bus_a_out(aBusA), .bus_r_nw_out(aRnw), .bus_d_out(aBusD), .bus_owner_out(aOwner),
    .stall_cnt_out(aStall), .stall_cnt_clr_in(stallClr)
  );

  cpumc_arb #(.DMA_MAX_BURST(256)) dutB (
    .clk_in(clk), .rst_in(rst),
    .cpu_a_in(cpuA), .cpu_r_nw_in(cpuRnw), .cpu_d_in(cpuD), .cpu_rdy_out(bRdy),
    .hci_req_in(hciReq), .hci_a_in(hciA), .hci_r_nw_in(hciRnw), .hci_d_in(hciD),
    .hci_gnt_out(bHciGnt),
    .dma_req_in(dmaReq), .dma_a_in(dmaA), .dma_r_nw_in(dmaRnw), .dma_d_in(dmaD),
    .dma_gnt_out(bDmaGnt),
    .bus_a_out(bBusA), .bus_r_nw_out(bRnw), .bus_d_out(bBusD), .bus_owner_out(bOwner),
    .stall_cnt_out(bStall), .stall_cnt_clr_in(stallClr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic hReq, input logic dReq, input logic clr);
    hciReq   = hReq;
    dmaReq   = dReq;
    stallClr = clr;
    #1;
  endtask

  // Owner seen after the k-th edge of a held DMA request with a 256-cycle burst limit.
  function automatic logic [1:0] burstOwner(input int k);
    int j;
    if (k == 1) return 2'd1;
    j = (k - 2) % 259;
    if (j < 256)  return 2'd2;
    if (j == 257) return 2'd0;
    return 2'd1;
  endfunction

  initial begin
    logic [1:0] expOwner;
    rst = 1'b1;
    cpuA = 16'h0000; cpuRnw = 1'b1; cpuD = 8'h00;
    hciA = 16'h4000; hciRnw = 1'b1; hciD = 8'h00;
    dmaA = 16'h0200; dmaRnw = 1'b0; dmaD = 8'hAA;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    cpuA = 16'h0005; cpuRnw = 1'b0; cpuD = 8'h3C;
    #1;
    checkOutput("rstBusA", aBusA, 16'h0005);
    checkOutput("rstRnw", aRnw, 1'b0);
    checkOutput("rstBusD", aBusD, 8'h3C);
    checkOutput("rstRdy", aRdy, 1'b1);
    checkOutput("rstOwner", aOwner, 2'd0);
    checkOutput("rstStall", aStall, 16'd0);
    checkOutput("rstGnts", {aHciGnt, aDmaGnt}, 2'b00);

    // Short DMA burst, 4 request edges.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("dmaTurnOwner", aOwner, 2'd1);
    checkOutput("dmaTurnA", aBusA, 16'h0000);
    checkOutput("dmaTurnRnw", aRnw, 1'b1);
    checkOutput("dmaTurnD", aBusD, 8'h00);
    checkOutput("dmaTurnGnt", {aRdy, aDmaGnt}, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("dmaGnt", {aOwner, aDmaGnt, aRdy}, {2'd2, 1'b1, 1'b0});
      checkOutput("dmaBus", {aBusA, aRnw, aBusD}, {16'h0200, 1'b0, 8'hAA});
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("dmaExitTurn", {aOwner, aDmaGnt}, {2'd1, 1'b0});
    tick();
    checkOutput("dmaBackCpu", {aOwner, aRdy}, {2'd0, 1'b1});
    checkOutput("dmaBackBus", aBusA, 16'h0005);
    checkOutput("dmaStall", aStall, 16'd5);
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("stallClr", aStall, 16'd0);

    // Long held DMA request: B yields every 256 cycles, A never does.
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 600; k++) begin
      tick();
      expOwner = burstOwner(k);
      checkOutput($sformatf("burstOwner%0d", k), bOwner, expOwner);
      checkOutput($sformatf("burstRdy%0d", k), bRdy, expOwner == 2'd0);
      if (expOwner == 2'd1) checkOutput($sformatf("turnRead%0d", k), bRnw, 1'b1);
      if (k >= 2) checkOutput($sformatf("unlimGnt%0d", k), aDmaGnt, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("burstEnd", {aOwner, bOwner}, 4'b0000);

    // HCI preempts a running DMA burst, then DMA resumes.
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(3);
    checkOutput("preDma", aDmaGnt, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("preemptTurn", {aOwner, aDmaGnt, aHciGnt}, {2'd1, 1'b0, 1'b0});
    tick();
    checkOutput("hciGnt", {aOwner, aHciGnt, aDmaGnt}, {2'd3, 1'b1, 1'b0});
    checkOutput("hciBus", {aBusA, aRnw}, {16'h4000, 1'b1});
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("hciRelTurn", {aOwner, aHciGnt}, {2'd1, 1'b0});
    tick();
    checkOutput("dmaResume", {aOwner, aDmaGnt}, {2'd2, 1'b1});
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("resumeEnd", aOwner, 2'd0);

    // Simultaneous requests: HCI first; DMA withdrawn during the following TURN.
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("simTurn", aOwner, 2'd1);
    tick();
    checkOutput("simHci", {aHciGnt, aDmaGnt}, 2'b10);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("simTurn2", aOwner, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("dropToCpu", {aOwner, aRdy, aDmaGnt}, {2'd0, 1'b1, 1'b0});

    // Stall counter saturation and clear-over-increment.
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(65535);
    checkOutput("stallFFFE", aStall, 16'hFFFE);
    tick();
    checkOutput("stallFFFF", aStall, 16'hFFFF);
    tick();
    checkOutput("stallSat", aStall, 16'hFFFF);
    applyStimulus(1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("clrWins", aStall, 16'd0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("stallAfterClr", aStall, 16'd1);

    // Reset in the middle of a DMA burst.
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick(2);
    checkOutput("preRstDma", aDmaGnt, 1'b1);
    rst = 1'b1;
    tick();
    checkOutput("rstMidOwner", aOwner, 2'd0);
    checkOutput("rstMidGnts", {aHciGnt, aDmaGnt, aRdy}, 3'b001);
    checkOutput("rstMidStall", aStall, 16'd0);
    checkOutput("rstMidBus", aBusA, 16'h0005);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
